led_pulse_stretch: RTL

//  Output-side counterpart to the pushbutton debouncer. It turns single-clock event pulses and

---
 rtl/led_pulse_stretch.sv | 135 +++++++++++++
 1 files changed

// File: rtl/led_pulse_stretch.sv
// -----------------------------------------------------------------------------
// led_pulse_stretch
//
// Turns single-clock event pulses and level/blink requests from the core into
// human-visible LED drive. A shared prescaler makes a slow tick. Each channel
// keeps its LED lit for hold_ticks ticks after a pulse. Every new pulse reloads
// the hold instead of adding to it.
//
// Optional feature macro: LED_PWM_EN
//   When defined, the block adds the brightness port and a free-running PWM
//   counter. The LEDs are then dimmed by the shared duty. busy_out is not dimmed.
//
// Ports
//   clock       in   1         system clock
//   reset       in   1         asynchronous, active-high; clears all state
//   pulse_in    in   num       1-clock event pulses, one per channel
//   level_in    in   num       LED forced on while 1
//   blink_in    in   num       LED follows the blink phase while 1
//   brightness  in   pwm_bits  shared LED duty (only with LED_PWM_EN)
//   leds_out    out  num       registered LED drive
//   busy_out    out  num       registered; 1 while the channel hold is nonzero
// -----------------------------------------------------------------------------
module led_pulse_stretch #(
  parameter int num           = 8,
  parameter int prescale_bits = 20,
  parameter int hold_ticks    = 3,
  parameter int pwm_bits      = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [num-1:0]      pulse_in,
  input  logic [num-1:0]      level_in,
  input  logic [num-1:0]      blink_in,
`ifdef LED_PWM_EN
  input  logic [pwm_bits-1:0] brightness,
`endif
  output logic [num-1:0]      leds_out,
  output logic [num-1:0]      busy_out
);

  localparam logic [7:0]               hold_load = 8'(hold_ticks);
  localparam logic [prescale_bits-1:0] pre_one   = {{(prescale_bits-1){1'b0}}, 1'b1};

  logic [prescale_bits-1:0] prescale_r;
  logic                     tick_s;
  logic                     blink_phase_r;
  logic                     blink_phase_next_s;
  logic [7:0]               hold_r      [num];
  logic [7:0]               hold_next_s [num];
  logic [num-1:0]           busy_next_s;
  logic [num-1:0]           on_next_s;
  logic [num-1:0]           leds_next_s;

  // Tick fires in the single cycle where the prescaler is all ones; blink phase flips on it.
  always_comb begin
    tick_s             = &prescale_r;
    blink_phase_next_s = blink_phase_r ^ tick_s;
  end

  // Per-channel hold next state: a pulse reloads (and beats a coincident tick),
  // a tick counts a nonzero hold down, otherwise the hold is kept.
  always_comb begin
    for (int i = 0; i < num; i++) begin
      hold_next_s[i] = hold_r[i];
      if (pulse_in[i]) begin
        hold_next_s[i] = hold_load;
      end else if (tick_s && (hold_r[i] != 8'd0)) begin
        hold_next_s[i] = hold_r[i] - 8'd1;
      end else begin
        hold_next_s[i] = hold_r[i];
      end
    end
  end

  // LED request per channel, computed from next-state values so outputs track with one edge latency.
  always_comb begin
    busy_next_s = '0;
    on_next_s   = '0;
    for (int i = 0; i < num; i++) begin
      busy_next_s[i] = (hold_next_s[i] != 8'd0);
      on_next_s[i]   = busy_next_s[i] | level_in[i] | (blink_in[i] & blink_phase_next_s);
    end
  end

`ifdef LED_PWM_EN
  localparam logic [pwm_bits-1:0] pwm_one = {{(pwm_bits-1){1'b0}}, 1'b1};

  logic [pwm_bits-1:0] pwm_cnt_r;
  logic [pwm_bits-1:0] pwm_cnt_next_s;
  logic                pwm_on_s;

  // PWM gate: lit while the next counter value is below the duty, so brightness 0 is always dark.
  always_comb begin
    pwm_cnt_next_s = pwm_cnt_r + pwm_one;
    pwm_on_s       = (pwm_cnt_next_s < brightness);
    leds_next_s    = on_next_s & {num{pwm_on_s}};
  end

  // Free-running PWM counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_cnt_r <= '0;
    end else begin
      pwm_cnt_r <= pwm_cnt_next_s;
    end
  end
`else
  // Without PWM the LED drive is the raw request.
  always_comb begin
    leds_next_s = on_next_s;
  end
`endif

  // State and output registers; reset clears everything immediately, including a hold in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescale_r    <= '0;
      blink_phase_r <= 1'b0;
      leds_out      <= '0;
      busy_out      <= '0;
      for (int i = 0; i < num; i++) begin
        hold_r[i] <= 8'd0;
      end
    end else begin
      prescale_r    <= prescale_r + pre_one;
      blink_phase_r <= blink_phase_next_s;
      leds_out      <= leds_next_s;
      busy_out      <= busy_next_s;
      for (int i = 0; i < num; i++) begin
        hold_r[i] <= hold_next_s[i];
      end
    end
  end

endmodule
